// File: rtl/period_meter_pkg.sv
// Shared types and constants for the period meter.
// Latency: n/a (declarations only).
// Backpressure: n/a; no flow control in this block.
package period_meter_pkg;

    // Default bit width of the measured period, expected value and counter.
    localparam int WIDTH_DEFAULT = 8;

    // Measurement controller states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_COUNT = 2'd2,
        ST_OVF   = 2'd3
    } state_e;

endpackage : period_meter_pkg

// File: rtl/period_meter_edge_detect.sv
// Rising-edge detector: flags the cycle where in=1 and its previous value was 0.
// Latency: combinational rise output from the current input and one history flop.
// Backpressure: none; a level held high yields a single rise.
// Ports: clk, rst (sync, active-high), in (level), rise (one-cycle flag).
module edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic rise
);

    logic prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= in;
        end
    end

    assign rise = in & ~prev_q;

endmodule : edge_detect

// File: rtl/period_meter.sv
// Measures clk cycles between consecutive rising edges of pulse_in and compares with expected.
// Latency: valid/period/ovf/match are registered one cycle after the closing edge.
// Backpressure: none; one strobe per measured period, results hold until the next strobe.
// Ports: clk, rst (sync, active-high), en, pulse_in, expected[WIDTH]
//        -> period[WIDTH], valid, ovf, match, locked.
module period_meter
    import period_meter_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             pulse_in,
    input  logic [WIDTH-1:0] expected,
    output logic [WIDTH-1:0] period,
    output logic             valid,
    output logic             ovf,
    output logic             match,
    output logic             locked
);

    localparam logic [WIDTH-1:0] CNT_MAX = '1;
    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

    logic             rise;
    state_e           state_q,  state_d;
    logic [WIDTH-1:0] cnt_q,    cnt_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic             valid_q,  valid_d;
    logic             ovf_q,    ovf_d;
    logic             match_q,  match_d;

    edge_detect u_edge_detect (
        .clk  (clk),
        .rst  (rst),
        .in   (pulse_in),
        .rise (rise)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            period_q <= '0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
            match_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
            match_q  <= match_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        period_d = period_q;
        valid_d  = 1'b0;
        ovf_d    = ovf_q;
        match_d  = match_q;

        // Disabling drops any partial count; results hold, and an edge in this
        // same cycle is deliberately lost.
        if (!en) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_ARMED;
                end
                ST_ARMED: begin
                    // First edge only opens the measurement window.
                    if (rise) begin
                        state_d = ST_COUNT;
                        cnt_d   = CNT_ONE;
                    end
                end
                ST_COUNT: begin
                    // cnt equals cycles elapsed since the opening edge, so an
                    // edge landing on CNT_MAX is still an exact, in-range result.
                    if (rise) begin
                        period_d = cnt_q;
                        valid_d  = 1'b1;
                        ovf_d    = 1'b0;
                        match_d  = (cnt_q == expected);
                        cnt_d    = CNT_ONE;
                    end else if (cnt_q == CNT_MAX) begin
                        state_d = ST_OVF;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                ST_OVF: begin
                    // cnt stays saturated here; the closing edge reports overflow
                    // and simultaneously opens the next window.
                    if (rise) begin
                        period_d = CNT_MAX;
                        ovf_d    = 1'b1;
                        match_d  = 1'b0;
                        valid_d  = 1'b1;
                        cnt_d    = CNT_ONE;
                        state_d  = ST_COUNT;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    assign period = period_q;
    assign valid  = valid_q;
    assign ovf    = ovf_q;
    assign match  = match_q;
    assign locked = (state_q == ST_COUNT) || (state_q == ST_OVF);

endmodule : period_meter

// File: tb/tb_period_meter.sv
// Self-checking bench for period_meter: directed scenarios plus random pulse trains.
// Latency: reference model predicts outputs one cycle after each sampled edge.
// Backpressure: n/a.
module tb_period_meter;

    localparam int W    = 8;
    localparam int MAXV = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         rst_r, en_r, pulse_r;
    logic [W-1:0] exp_r;
    logic [W-1:0] period;
    logic         valid, ovf, match, locked;

    period_meter #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst_r),
        .en       (en_r),
        .pulse_in (pulse_r),
        .expected (exp_r),
        .period   (period),
        .valid    (valid),
        .ovf      (ovf),
        .match    (match),
        .locked   (locked)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_bad = 0;

    // Reference model: timestamps of edges, phase 0=off, 1=waiting first edge, 2=measuring.
    int           now   = 0;
    int           phase = 0;
    int           t1    = 0;
    bit           m_prev = 1'b0;
    logic [W-1:0] m_period = '0;
    bit           m_valid = 1'b0, m_ovf = 1'b0, m_match = 1'b0, m_locked = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_chk++;
        if (obs !== want) begin
            n_bad++;
            $display("FAIL %s @cycle %0d: got %h want %h", tag, now, obs, want);
        end
    endtask

    task automatic model_step();
        bit rise;
        int gap_c;
        rise    = pulse_r && !m_prev;
        m_valid = 1'b0;
        if (rst_r) begin
            phase    = 0;
            m_prev   = 1'b0;
            m_period = '0;
            m_ovf    = 1'b0;
            m_match  = 1'b0;
        end else begin
            m_prev = pulse_r;
            if (!en_r) begin
                phase = 0;
            end else if (phase == 0) begin
                phase = 1;
            end else if (rise) begin
                if (phase == 1) begin
                    phase = 2;
                    t1    = now;
                end else begin
                    gap_c   = now - t1;
                    t1      = now;
                    m_valid = 1'b1;
                    if (gap_c > MAXV) begin
                        m_period = W'(MAXV);
                        m_ovf    = 1'b1;
                        m_match  = 1'b0;
                    end else begin
                        m_period = W'(gap_c);
                        m_ovf    = 1'b0;
                        m_match  = (gap_c == int'(exp_r));
                    end
                end
            end
        end
        m_locked = (phase == 2);
        now++;
    endtask

    task automatic tick(input bit p);
        pulse_r = p;
        @(posedge clk);
        model_step();
        #1;
        chk("outs", {20'd0, valid, locked, ovf, match, period},
                    {20'd0, m_valid, m_locked, m_ovf, m_match, m_period});
    endtask

    // One high cycle then low cycles: consecutive calls give edges n apart.
    task automatic gap(input int n);
        tick(1'b1);
        repeat (n - 1) tick(1'b0);
    endtask

    task automatic pulse_hl(input int hi, input int lo);
        repeat (hi) tick(1'b1);
        repeat (lo) tick(1'b0);
    endtask

    initial begin
        int dc;
        rst_r   = 1'b1;
        en_r    = 1'b0;
        pulse_r = 1'b0;
        exp_r   = W'(10);
        repeat (2) tick(1'b0);
        chk("rst_zero", {20'd0, valid, locked, ovf, match, period}, 32'd0);
        rst_r = 1'b0;
        en_r  = 1'b1;
        repeat (3) tick(1'b0);

        // Every 10 cycles, expected 10.
        repeat (12) gap(10);
        chk("a_per", period, 10);
        chk("a_match", match, 1);
        chk("a_ovf", ovf, 0);

        // Divide-by-113 counter driving pulse_in.
        exp_r = W'(113);
        dc    = 113;
        repeat (8 * 113) begin
            tick(dc == 1);
            dc = (dc == 1) ? 113 : dc - 1;
        end
        chk("b_per", period, 113);
        chk("b_match", match, 1);
        exp_r = W'(112);
        repeat (2 * 113 + 2) begin
            tick(dc == 1);
            dc = (dc == 1) ? 113 : dc - 1;
        end
        chk("b_per2", period, 113);
        chk("b_match2", match, 0);

        // Overflow gap of 300 followed by 20.
        exp_r = W'(20);
        gap(10);
        gap(300);
        gap(20);
        chk("c_per", period, 255);
        chk("c_ovf", ovf, 1);
        chk("c_match", match, 0);
        chk("c_lock", locked, 1);
        gap(5);
        chk("c_per2", period, 20);
        chk("c_ovf2", ovf, 0);
        chk("c_match2", match, 1);

        // Exactly full-scale, then minimum.
        gap(255);
        gap(2);
        chk("d_per", period, 255);
        chk("d_ovf", ovf, 0);
        gap(3);
        chk("d_per2", period, 2);

        // Reset five cycles after an edge mid-measurement.
        repeat (3) gap(10);
        tick(1'b1);
        repeat (5) tick(1'b0);
        rst_r = 1'b1;
        tick(1'b0);
        rst_r = 1'b0;
        chk("e_rst", {20'd0, valid, locked, ovf, match, period}, 32'd0);
        repeat (4) gap(10);
        chk("e_per", period, 10);

        // Long high pulses, then en dropped mid-period.
        exp_r = W'(60);
        repeat (5) pulse_hl(50, 10);
        chk("f_per", period, 60);
        chk("f_match", match, 1);
        pulse_hl(30, 0);
        en_r = 1'b0;
        pulse_hl(20, 10);
        tick(1'b1);
        tick(1'b0);
        chk("f_hold", period, 60);
        chk("f_lock", locked, 0);
        en_r = 1'b1;

        // Random pulse trains with occasional en drops and resets.
        for (int i = 0; i < 150; i++) begin
            int n, hi;
            case ($urandom_range(0, 5))
                0:       n = $urandom_range(2, 6);
                1:       n = 255 + $urandom_range(0, 2) - 1;
                2:       n = $urandom_range(100, 320);
                default: n = $urandom_range(5, 40);
            endcase
            exp_r = ($urandom_range(0, 1) == 1) ? W'(n) : W'($urandom);
            if ($urandom_range(0, 14) == 0) en_r = 1'b0;
            else                            en_r = 1'b1;
            if ($urandom_range(0, 29) == 0) begin
                rst_r = 1'b1;
                tick(1'b0);
                rst_r = 1'b0;
            end
            hi = $urandom_range(1, n - 1);
            pulse_hl(hi, n - hi);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule : tb_period_meter
